// File: rtl/counter_cascade_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_cascade_if: control/data bundle for counter_cascade.        Rev 1.0
// ----------------------------------------------------------------------------
interface counter_cascade_if #(
  parameter int DIGITS = 4,
  parameter int DW     = 4
) ();
  logic                   en_i;
  logic                   up_i;
  logic                   clr_i;
  logic                   load_i;
  logic [DIGITS*DW-1:0]   load_val_i;
  logic [DIGITS*DW-1:0]   count_o;
  logic                   tc_o;
  logic                   ovf_o;

  modport master (
    output en_i, up_i, clr_i, load_i, load_val_i,
    input  count_o, tc_o, ovf_o
  );

  modport slave (
    input  en_i, up_i, clr_i, load_i, load_val_i,
    output count_o, tc_o, ovf_o
  );
endinterface
`default_nettype wire

// File: rtl/counter_cascade.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_cascade: multi-digit modulo-M up/down counter, sticky ovf.  Rev 1.0
// ----------------------------------------------------------------------------
module counter_cascade #(
  parameter int DIGITS = 4,
  parameter int M      = 10,
  parameter int DW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  counter_cascade_if.slave   cnt_if
);

  localparam logic [DW-1:0] LAST = DW'(M - 1);

  logic [DIGITS-1:0][DW-1:0] count_q;
  logic [DIGITS-1:0][DW-1:0] count_d;
  logic [DIGITS-1:0][DW-1:0] load_d;
  logic                      ovf_q;
  logic                      wrap_d;

  // A digit steps while every digit below it sits at its terminal value;
  // the carry out of the top digit is the whole-counter wrap.
  always_comb begin
    logic          step;
    logic [DW-1:0] dig;
    logic [DW-1:0] fld;
    step    = 1'b1;
    dig     = '0;
    fld     = '0;
    count_d = count_q;
    load_d  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = count_q[i];
      if (step) begin
        if (cnt_if.up_i) count_d[i] = (dig == LAST) ? '0 : dig + DW'(1);
        else             count_d[i] = (dig == '0) ? LAST : dig - DW'(1);
      end
      step = step & (cnt_if.up_i ? (dig == LAST) : (dig == '0));
      fld       = cnt_if.load_val_i[i*DW +: DW];
      load_d[i] = (fld > LAST) ? LAST : fld;
    end
    wrap_d = step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (cnt_if.clr_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (cnt_if.load_i) begin
      count_q <= load_d;
      ovf_q   <= 1'b0;
    end else if (cnt_if.en_i) begin
      count_q <= count_d;
      if (wrap_d) ovf_q <= 1'b1;
    end
  end

  assign cnt_if.count_o = count_q;
  assign cnt_if.ovf_o   = ovf_q;
  assign cnt_if.tc_o    = cnt_if.en_i & wrap_d;

endmodule
`default_nettype wire

// File: doc/counter_cascade.md
# counter_cascade

Parametrised multi-digit modulo-M up/down counter for the display path: a chain of DIGITS digit counters, each counting 0..M-1, with ripple carry/borrow between digits, synchronous load and clear, a terminal-count output for cascading further stages, and a sticky overflow flag. It replaces single-digit modulo counters wherever a multi-digit value (e.g. 4-digit decimal) drives a digit displayer directly.

## Interface
- DIGITS, 4, number of cascaded digits (≥1)
- M, 10, modulus of every digit (2 ≤ M ≤ 2^DW)
- DW, 4, bits per digit; DW ≥ ceil(log2(M))

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- clr  input  1  synchronous clear of count and ovf
- load  input  1  synchronous parallel load
- load_val  input  DIGITS*DW  load value, digit i in bits [i*DW +: DW]
- count  output  DIGITS*DW  registered count, digit 0 = least significant, digit i in bits [i*DW +: DW]
- tc  output  1  terminal count (combinational): next enabled step wraps the whole counter
- ovf  output  1  sticky wrap flag (registered)

## Operation
- Priority per edge: rst (async) > clr > load > en; lower-priority actions ignored that cycle.
- rst: count = 0, ovf = 0 immediately, independent of clk.
- clr: count = 0, ovf = 0.
- load: each digit takes its load_val field; a field ≥ M is clamped to M-1. ovf = 0. en ignored.
- en with up=1: digit 0 steps +1 each cycle; digit i (i>0) steps iff every lower digit equals M-1. A stepping digit at M-1 wraps to 0.
- en with up=0: digit 0 steps -1; digit i steps iff every lower digit equals 0. A stepping digit at 0 wraps to M-1.
- Whole-counter wrap: up from all-(M-1) to all-0, or down from all-0 to all-(M-1). On that edge ovf is set to 1 and stays 1 until clr, load or rst.
- tc = en & up & (all digits == M-1) | en & ~up & (all digits == 0). Cascading: next counter_cascade's en = tc of this one.
- en low: count and ovf hold.
- Direction change mid-count allowed; takes effect on the next edge, no extra state.
- Digit comparison and arithmetic performed at DW bits; digit values never exceed M-1 in any reachable state (including after load).
- DIGITS=1 degenerates to a single modulo-M up/down counter with tc and ovf.

## Timing
- count, ovf: registered, update one clk edge after the controlling input is sampled; latency 1 cycle.
- tc: combinational from registered count, en, up; valid in the same cycle as en, asserted in the cycle whose edge performs the wrap.
- ovf rises on the same edge that count wraps (visible the cycle after tc).
- Carry/borrow evaluated combinationally across all digits within one cycle; no multi-cycle ripple.
- rst asserted mid-count: outputs go to 0 asynchronously; first count step occurs on the first edge with rst low and en high.
- Reset values: count = 0, ovf = 0, tc = 0 when en = 0 or up = 1 at count 0 (tc = en & ~up at reset, since count = 0).

## Test plan
- Reset/hold: rst pulse mid-count (count = 0x0357) -> count = 0x0000, ovf = 0 without clk edge; en=0 for 5 cycles -> count stays 0x0000.
- Up wrap, DIGITS=4 M=10 DW=4: load 0x9998, en=1 up=1 -> 0x9999 (tc=1 that cycle) -> 0x0000, ovf=1; further counting keeps ovf=1 until clr.
- Down borrow: load 0x1000, en=1 up=0 -> 0x0999 -> 0x0998; from 0x0000 with tc=1 -> 0x9999, ovf=1.
- Load clamp/priority: load_val = 0xC3F1 with load=1, en=1 -> count = 0x9391, ovf = 0; clr=1 and load=1 same cycle -> count = 0x0000.
- Non-decimal: DIGITS=2 M=6 DW=3 up from 0 -> digit sequence 00..05,10..55, then 00 with ovf=1 after exactly 36 enabled cycles.
- Cascade: two instances, second en = first tc; run 10,001 up steps from 0 on DIGITS=4 M=10 -> first = 0x0001, second = 0x0001, first ovf = 1, second ovf = 0.
